// File: rtl/channel_rle_pkg.sv
// Shared types and constants for the channel run-length encoder.
package channel_rle_pkg;

   localparam int unsigned CODE_W    = 3;
   localparam int unsigned RUN_W_DEF = 5;

   // One emitted run: channel code and number of consecutive samples.
   typedef struct packed {
      logic [CODE_W-1:0]    code;
      logic [RUN_W_DEF-1:0] run;
   } rle_token_t;

   // Run tracker states.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } rle_state_e;

endpackage

// File: rtl/rle_fifo.sv
// Synchronous token FIFO; a push into a full FIFO is accepted only when a pop frees a slot.
module rle_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] count;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   // Head is forced to zero while empty so stale storage never shows on the outputs.
   assign rdata   = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   // Token storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/channel_rle.sv
// Run-length encoder for priority-encoded spectrogram channel codes with a token FIFO.
module channel_rle
   import channel_rle_pkg::*;
#(
   parameter int unsigned RUN_W      = RUN_W_DEF,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            sample_en,
   input  logic [CODE_W-1:0]               channel_code,
   input  logic                            flush,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [CODE_W-1:0]               out_code,
   output logic [RUN_W-1:0]                out_run,
   output logic                            overflow,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

   localparam int unsigned TOK_W = CODE_W + RUN_W;
   localparam logic [0:0]  ST_IDLE = 1'(IDLE);
   localparam logic [0:0]  ST_RUN  = 1'(RUN);
   localparam logic [RUN_W-1:0] RUN_MAX = '1;

   logic [0:0]        state;
   logic [0:0]        nxt_state;
   logic [CODE_W-1:0] cur_code;
   logic [CODE_W-1:0] nxt_code;
   logic [RUN_W-1:0]  cur_cnt;
   logic [RUN_W-1:0]  nxt_cnt;
   logic              push_c;
   logic              pop_c;
   logic              fifo_full;
   logic              fifo_empty;
   logic [TOK_W-1:0]  head;

   assign out_valid = !fifo_empty;
   assign pop_c     = out_valid && out_ready;
   assign out_code  = head[TOK_W-1:RUN_W];
   assign out_run   = head[RUN_W-1:0];

   // Run tracker state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cur_code <= '0;
         cur_cnt  <= '0;
      end else begin
         state    <= nxt_state;
         cur_code <= nxt_code;
         cur_cnt  <= nxt_cnt;
      end
   end

   // Next-state and push decision; the pushed token is always the run being closed.
   always_comb begin
      nxt_state = state;
      nxt_code  = cur_code;
      nxt_cnt   = cur_cnt;
      push_c    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sample_en) begin
               nxt_state = ST_RUN;
               nxt_code  = channel_code;
               nxt_cnt   = RUN_W'(1);
            end
         end
         ST_RUN: begin
            if (flush) begin
               push_c = 1'b1;
               if (sample_en) begin
                  nxt_code = channel_code;
                  nxt_cnt  = RUN_W'(1);
               end else begin
                  nxt_state = ST_IDLE;
                  nxt_code  = '0;
                  nxt_cnt   = '0;
               end
            end else if (sample_en) begin
               // A saturated run splits rather than wrapping to zero.
               if ((channel_code != cur_code) || (cur_cnt == RUN_MAX)) begin
                  push_c   = 1'b1;
                  nxt_code = channel_code;
                  nxt_cnt  = RUN_W'(1);
               end else begin
                  nxt_cnt = cur_cnt + RUN_W'(1);
               end
            end
         end
         default: begin
            nxt_state = ST_IDLE;
            nxt_code  = '0;
            nxt_cnt   = '0;
         end
      endcase
   end

   // Sticky drop flag: a push that the full FIFO could not absorb this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (push_c && fifo_full && !pop_c) begin
         overflow <= 1'b1;
      end
   end

   rle_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (TOK_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_c),
      .pop   (pop_c),
      .wdata ({cur_code, cur_cnt}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

endmodule

// File: tb/tb_channel_rle.sv
// Directed and randomized bench for channel_rle against a queue-based reference model.
module tb_channel_rle;
   import channel_rle_pkg::*;

   localparam int MAXRUN = 31;
   localparam int DEPTH  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_en;
   logic [2:0] channel_code;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_code;
   logic [4:0] out_run;
   logic       overflow;
   logic [2:0] fifo_level;

   always #5 clk = ~clk;

   channel_rle #(.RUN_W(5), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_en    (sample_en),
      .channel_code (channel_code),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_code     (out_code),
      .out_run      (out_run),
      .overflow     (overflow),
      .fifo_level   (fifo_level)
   );

   int nchk  = 0;
   int npass = 0;

   // Reference model: expected FIFO contents, open run, sticky flag.
   rle_token_t mq[$];
   rle_token_t log_q[$];
   bit         m_open;
   int         m_code;
   int         m_cnt;
   bit         m_ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic check_outputs();
      chk("valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("level", 32'(fifo_level), 32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (mq.size() != 0) begin
         chk("head_code", 32'(out_code), 32'(mq[0].code));
         chk("head_run", 32'(out_run), 32'(mq[0].run));
      end
   endtask

   // One clock: check, log any DUT pop, drive inputs, advance model, cross the edge.
   task automatic step(input bit se, input int code, input bit fl, input bit rdy);
      bit         popping;
      bit         was_full;
      bit         pushing;
      rle_token_t tok;
      check_outputs();
      if (out_valid && rdy) log_q.push_back(rle_token_t'{code: out_code, run: out_run});
      sample_en    = se;
      channel_code = 3'(code);
      flush        = fl;
      out_ready    = rdy;
      pushing = 1'b0;
      tok     = rle_token_t'{code: 3'(m_code), run: 5'(m_cnt)};
      if (!m_open) begin
         if (se) begin m_open = 1'b1; m_code = code; m_cnt = 1; end
      end else if (fl) begin
         pushing = 1'b1;
         if (se) begin m_code = code; m_cnt = 1; end
         else m_open = 1'b0;
      end else if (se) begin
         if (code != m_code || m_cnt == MAXRUN) begin
            pushing = 1'b1; m_code = code; m_cnt = 1;
         end else begin
            m_cnt++;
         end
      end
      popping  = rdy && (mq.size() != 0);
      was_full = (mq.size() == DEPTH);
      if (popping) void'(mq.pop_front());
      if (pushing) begin
         if (was_full && !popping) m_ovf = 1'b1;
         else mq.push_back(tok);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input bit se, input bit fl, input bit rdy);
      rst          = 1'b1;
      sample_en    = se;
      channel_code = 3'd2;
      flush        = fl;
      out_ready    = rdy;
      mq.delete();
      log_q.delete();
      m_open = 1'b0; m_code = 0; m_cnt = 0; m_ovf = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; sample_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
   endtask

   task automatic drain(input int n);
      repeat (n) step(1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic chk_tok(input string tag, input int idx, input int code, input int run);
      rle_token_t t;
      t = 'x;
      if (idx < log_q.size()) t = log_q[idx];
      chk({tag, "_code"}, 32'(t.code), 32'(code));
      chk({tag, "_run"}, 32'(t.run), 32'(run));
   endtask

   initial begin
      rst = 1'b0; sample_en = 1'b0; channel_code = 3'd0; flush = 1'b0; out_ready = 1'b0;
      @(negedge clk);

      // Reset state
      do_reset(1'b0, 1'b0, 1'b0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_code", 32'(out_code), 32'd0);
      chk("rst_run", 32'(out_run), 32'd0);

      // 3,3,3,5 then flush
      do_reset(1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b1, 3, 1'b0, 1'b1);
      step(1'b1, 5, 1'b0, 1'b1);
      step(1'b0, 0, 1'b1, 1'b1);
      drain(3);
      chk("b_count", 32'(log_q.size()), 32'd2);
      chk_tok("b_tok0", 0, 3, 3);
      chk_tok("b_tok1", 1, 5, 1);
      chk("b_overflow", 32'(overflow), 32'd0);

      // Saturation split: 33 x code 7
      do_reset(1'b0, 1'b0, 1'b0);
      repeat (33) step(1'b1, 7, 1'b0, 1'b1);
      step(1'b0, 0, 1'b1, 1'b1);
      drain(3);
      chk("c_count", 32'(log_q.size()), 32'd2);
      chk_tok("c_tok0", 0, 7, 31);
      chk_tok("c_tok1", 1, 7, 2);

      // Overflow with stalled consumer
      do_reset(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, (i % 2 == 0) ? 1 : 2, 1'b0, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0);
      chk("d_level", 32'(fifo_level), 32'd4);
      chk("d_overflow", 32'(overflow), 32'd1);
      drain(6);
      chk("d_count", 32'(log_q.size()), 32'd4);
      chk_tok("d_tok0", 0, 1, 1);
      chk_tok("d_tok1", 1, 2, 1);
      chk_tok("d_tok2", 2, 1, 1);
      chk_tok("d_tok3", 3, 2, 1);
      chk("d_sticky", 32'(overflow), 32'd1);

      // Flush together with a new sample
      do_reset(1'b0, 1'b0, 1'b0);
      repeat (2) step(1'b1, 4, 1'b0, 1'b1);
      step(1'b1, 6, 1'b1, 1'b1);
      step(1'b0, 0, 1'b1, 1'b1);
      drain(3);
      chk("e_count", 32'(log_q.size()), 32'd2);
      chk_tok("e_tok0", 0, 4, 2);
      chk_tok("e_tok1", 1, 6, 1);

      // Full FIFO with simultaneous push and pop
      do_reset(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, (i % 2 == 0) ? 1 : 2, 1'b0, 1'b0);
      chk("f_full_level", 32'(fifo_level), 32'd4);
      step(1'b1, 2, 1'b0, 1'b1);
      chk("f_level", 32'(fifo_level), 32'd4);
      chk("f_overflow", 32'(overflow), 32'd0);
      chk_tok("f_tok0", 0, 1, 1);
      drain(6);

      // Reset mid-run with buffered tokens, colliding with sample/flush/ready
      do_reset(1'b0, 1'b0, 1'b0);
      step(1'b1, 5, 1'b0, 1'b0);
      step(1'b1, 6, 1'b0, 1'b0);
      repeat (3) step(1'b1, 2, 1'b0, 1'b0);
      chk("g_level_pre", 32'(fifo_level), 32'd2);
      do_reset(1'b1, 1'b1, 1'b1);
      chk("g_valid", 32'(out_valid), 32'd0);
      chk("g_level", 32'(fifo_level), 32'd0);
      drain(3);
      step(1'b0, 0, 1'b1, 1'b1);
      drain(2);
      chk("g_no_tokens", 32'(log_q.size()), 32'd0);

      // Randomized traffic against the model
      do_reset(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 600; i++) begin
         bit se, fl, rdy;
         int code;
         se   = ($urandom_range(0, 3) != 0);
         if (i >= 300 && i < 400) begin
            code = 5;
            fl   = 1'b0;
         end else begin
            code = int'($urandom_range(0, 2));
            fl   = ($urandom_range(0, 15) == 0);
         end
         rdy = ((i % 150) < 40) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         step(se, code, fl, rdy);
      end
      drain(6);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
